fence_flush_sequencer: RTL and testbench

//  Parametrised pipeline-flush and fence sequencer; next-generation flush controller between commit/CSR and frontend/caches/MMU.

---
 rtl/fence_flush_if.sv | 57 +++++
 rtl/fence_flush_sequencer.sv | 109 ++++++++++
 tb/tb_fence_flush_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fence_flush_if.sv
// Commit/CSR-side bundle for the flush and fence sequencer: flush causes in,
// per-stage flush strobes, D$ bank handshakes and fence status out.
interface fence_flush_if #(
    parameter int unsigned NR_DCACHE_BANKS = 2,
    parameter int unsigned CNT_W           = 11
);
    logic                       v_i;
    logic                       mispredict_i;
    logic                       fence_req_i;
    logic                       fence_i_req_i;
    logic                       sfence_vma_i;
    logic                       hfence_vvma_i;
    logic                       hfence_gvma_i;
    logic                       flush_csr_i;
    logic                       flush_commit_i;
    logic                       ex_valid_i;
    logic                       eret_i;
    logic                       set_debug_pc_i;
    logic                       halt_csr_i;
    logic [NR_DCACHE_BANKS-1:0] flush_dcache_ack_i;

    logic                       set_pc_commit_o;
    logic                       flush_if_o;
    logic                       flush_unissued_instr_o;
    logic                       flush_id_o;
    logic                       flush_ex_o;
    logic                       flush_bp_o;
    logic                       flush_icache_o;
    logic [NR_DCACHE_BANKS-1:0] flush_dcache_o;
    logic                       flush_tlb_o;
    logic                       flush_tlb_vvma_o;
    logic                       flush_tlb_gvma_o;
    logic                       halt_o;
    logic                       fence_busy_o;
    logic                       fence_timeout_o;
    logic [CNT_W-1:0]           last_fence_cycles_o;

    modport slave (
        input  v_i, mispredict_i, fence_req_i, fence_i_req_i, sfence_vma_i,
               hfence_vvma_i, hfence_gvma_i, flush_csr_i, flush_commit_i,
               ex_valid_i, eret_i, set_debug_pc_i, halt_csr_i, flush_dcache_ack_i,
        output set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o,
               flush_ex_o, flush_bp_o, flush_icache_o, flush_dcache_o, flush_tlb_o,
               flush_tlb_vvma_o, flush_tlb_gvma_o, halt_o, fence_busy_o,
               fence_timeout_o, last_fence_cycles_o
    );

    modport master (
        output v_i, mispredict_i, fence_req_i, fence_i_req_i, sfence_vma_i,
               hfence_vvma_i, hfence_gvma_i, flush_csr_i, flush_commit_i,
               ex_valid_i, eret_i, set_debug_pc_i, halt_csr_i, flush_dcache_ack_i,
        input  set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o,
               flush_ex_o, flush_bp_o, flush_icache_o, flush_dcache_o, flush_tlb_o,
               flush_tlb_vvma_o, flush_tlb_gvma_o, halt_o, fence_busy_o,
               fence_timeout_o, last_fence_cycles_o
    );
endinterface

// File: rtl/fence_flush_sequencer.sv
// Flush-cause decoder plus FENCE/FENCE.I sequencer: per-bank D$ write-back with
// timeout abort, I$ invalidate ordered after the D$ completes.
module fence_flush_sequencer #(
    parameter int unsigned NR_DCACHE_BANKS = 2,
    parameter int unsigned WB_DCACHE       = 1,
    parameter int unsigned RVH             = 1,
    parameter int unsigned ACK_TIMEOUT     = 1024,
    parameter int unsigned CNT_W           = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fence_flush_if.slave   bus
);
    localparam bit HAS_H = (RVH != 0);
    localparam bit HAS_WB = (WB_DCACHE != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                     state_reg;
    logic [NR_DCACHE_BANKS-1:0] pending_reg;
    logic [NR_DCACHE_BANKS-1:0] pending_next;
    logic [CNT_W-1:0]           cnt_reg;
    logic [CNT_W-1:0]           last_reg;
    logic                       icache_def_reg;
    logic                       icache_pulse_reg;
    logic                       timeout_reg;

    logic live, exc, fence_any, fence_start, acks_done;

    // Strobes are gated by reset so every output reads 0 while it is held.
    assign live        = ~rst_i;
    assign exc         = bus.ex_valid_i | bus.eret_i | bus.set_debug_pc_i;
    assign fence_any   = bus.fence_req_i | bus.fence_i_req_i | bus.sfence_vma_i
                       | (HAS_H & (bus.hfence_vvma_i | bus.hfence_gvma_i))
                       | bus.flush_csr_i | bus.flush_commit_i;
    assign fence_start = HAS_WB & (bus.fence_req_i | bus.fence_i_req_i);

    for (genvar gi = 0; gi < NR_DCACHE_BANKS; gi++) begin : g_bank
        assign pending_next[gi] = pending_reg[gi] & ~bus.flush_dcache_ack_i[gi];
    end
    assign acks_done = (pending_next == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg        <= IDLE;
            pending_reg      <= '0;
            cnt_reg          <= '0;
            last_reg         <= '0;
            icache_def_reg   <= 1'b0;
            icache_pulse_reg <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            timeout_reg      <= 1'b0;
            icache_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fence_start) begin
                        state_reg      <= WAIT;
                        pending_reg    <= '1;
                        cnt_reg        <= CNT_W'(1);
                        icache_def_reg <= bus.fence_i_req_i;
                    end
                end
                WAIT: begin
                    // Completion is tested first so an ack on the timeout cycle wins.
                    if (acks_done) begin
                        state_reg        <= DONE;
                        pending_reg      <= '0;
                        last_reg         <= cnt_reg;
                        icache_pulse_reg <= icache_def_reg;
                        icache_def_reg   <= 1'b0;
                    end else if (cnt_reg == TIMEOUT_CNT) begin
                        state_reg      <= IDLE;
                        pending_reg    <= '0;
                        last_reg       <= cnt_reg;
                        timeout_reg    <= 1'b1;
                        icache_def_reg <= 1'b0;
                    end else begin
                        pending_reg <= pending_next;
                        cnt_reg     <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.set_pc_commit_o        = live & fence_any & ~exc;
    assign bus.flush_if_o             = live & (bus.mispredict_i | fence_any | exc);
    assign bus.flush_unissued_instr_o = live & (bus.mispredict_i | fence_any | exc);
    assign bus.flush_id_o             = live & (fence_any | exc);
    assign bus.flush_ex_o             = live & (fence_any | exc);
    assign bus.flush_bp_o             = live & exc;

    assign bus.flush_tlb_o      = live & bus.sfence_vma_i & ~(HAS_H & bus.v_i);
    assign bus.flush_tlb_vvma_o = live & HAS_H & ((bus.sfence_vma_i & bus.v_i) | bus.hfence_vvma_i);
    assign bus.flush_tlb_gvma_o = live & HAS_H & bus.hfence_gvma_i;

    // Write-through caches need no D$ ordering, so FENCE.I invalidates at once.
    assign bus.flush_icache_o = live & (icache_pulse_reg | (~HAS_WB & bus.fence_i_req_i));
    assign bus.flush_dcache_o = pending_reg;

    assign bus.halt_o              = live & (bus.halt_csr_i | (state_reg != IDLE));
    assign bus.fence_busy_o        = (state_reg != IDLE);
    assign bus.fence_timeout_o     = timeout_reg;
    assign bus.last_fence_cycles_o = last_reg;
endmodule

// File: tb/tb_fence_flush_sequencer.sv
// Scoreboard bench: three sequencer variants (WB+RVH, write-through, no RVH)
// driven in lockstep with directed vectors and hand-computed expectations.
module tb_fence_flush_sequencer;
    localparam int F_SETPC = 0, F_IF = 1, F_UN = 2, F_ID = 3, F_EX = 4, F_BP = 5;
    localparam int F_IC = 6, F_DC = 7, F_TLB = 8, F_VV = 9, F_GV = 10;
    localparam int F_HALT = 11, F_BUSY = 12, F_TO = 13, F_LAST = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v, mispredict, fence_req, fence_i, sfence, hvvma, hgvma;
    logic flush_csr, flush_commit, ex_valid, eret, dbg, halt_csr;
    logic [1:0] ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          dut;
        int          fld;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    logic [31:0] obs [3][15];

    fence_flush_if #(.NR_DCACHE_BANKS(2), .CNT_W(5)) bus [3] ();

    always #5 clk = ~clk;

    // 0: write-back + hypervisor, 1: write-through, 2: no hypervisor
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        fence_flush_sequencer #(
            .NR_DCACHE_BANKS(2),
            .WB_DCACHE      ((gi == 1) ? 0 : 1),
            .RVH            ((gi == 2) ? 0 : 1),
            .ACK_TIMEOUT    (16)
        ) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus[gi])
        );
        assign bus[gi].v_i                = v;
        assign bus[gi].mispredict_i       = mispredict;
        assign bus[gi].fence_req_i        = fence_req;
        assign bus[gi].fence_i_req_i      = fence_i;
        assign bus[gi].sfence_vma_i       = sfence;
        assign bus[gi].hfence_vvma_i      = hvvma;
        assign bus[gi].hfence_gvma_i      = hgvma;
        assign bus[gi].flush_csr_i        = flush_csr;
        assign bus[gi].flush_commit_i     = flush_commit;
        assign bus[gi].ex_valid_i         = ex_valid;
        assign bus[gi].eret_i             = eret;
        assign bus[gi].set_debug_pc_i     = dbg;
        assign bus[gi].halt_csr_i         = halt_csr;
        assign bus[gi].flush_dcache_ack_i = ack;

        assign obs[gi][F_SETPC] = 32'(bus[gi].set_pc_commit_o);
        assign obs[gi][F_IF]    = 32'(bus[gi].flush_if_o);
        assign obs[gi][F_UN]    = 32'(bus[gi].flush_unissued_instr_o);
        assign obs[gi][F_ID]    = 32'(bus[gi].flush_id_o);
        assign obs[gi][F_EX]    = 32'(bus[gi].flush_ex_o);
        assign obs[gi][F_BP]    = 32'(bus[gi].flush_bp_o);
        assign obs[gi][F_IC]    = 32'(bus[gi].flush_icache_o);
        assign obs[gi][F_DC]    = 32'(bus[gi].flush_dcache_o);
        assign obs[gi][F_TLB]   = 32'(bus[gi].flush_tlb_o);
        assign obs[gi][F_VV]    = 32'(bus[gi].flush_tlb_vvma_o);
        assign obs[gi][F_GV]    = 32'(bus[gi].flush_tlb_gvma_o);
        assign obs[gi][F_HALT]  = 32'(bus[gi].halt_o);
        assign obs[gi][F_BUSY]  = 32'(bus[gi].fence_busy_o);
        assign obs[gi][F_TO]    = 32'(bus[gi].fence_timeout_o);
        assign obs[gi][F_LAST]  = 32'(bus[gi].last_fence_cycles_o);
    end

    // Monitor: compares every expectation queued during the current cycle.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = obs[e.dut][e.fld];
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s dut%0d field%0d actual=%0h required=%0h",
                             e.tag, e.dut, e.fld, act, e.val);
                end else begin
                    $display("check %s dut%0d field%0d value=%0h ok", e.tag, e.dut, e.fld, act);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic expect_v(input string tag, input int d, input int f, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.dut = d; e.fld = f; e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        v = 0; mispredict = 0; fence_req = 0; fence_i = 0; sfence = 0; hvvma = 0; hgvma = 0;
        flush_csr = 0; flush_commit = 0; ex_valid = 0; eret = 0; dbg = 0; halt_csr = 0;
        ack = 2'b00;
    endtask

    initial begin
        clear();
        fence_req = 1; fence_i = 1; halt_csr = 1;
        tick();
        for (int d = 0; d < 3; d++) begin
            expect_v("rst_setpc", d, F_SETPC, 0); expect_v("rst_halt", d, F_HALT, 0);
            expect_v("rst_dc", d, F_DC, 0);       expect_v("rst_busy", d, F_BUSY, 0);
            expect_v("rst_to", d, F_TO, 0);       expect_v("rst_last", d, F_LAST, 0);
            expect_v("rst_ic", d, F_IC, 0);
        end
        tick(); clear(); rst = 0;
        tick();

        // T1: FENCE, ack bank0 at c4, bank1 at c7
        tick(); fence_req = 1;
        expect_v("t1_setpc", 0, F_SETPC, 1); expect_v("t1_if", 0, F_IF, 1);
        expect_v("t1_un", 0, F_UN, 1);       expect_v("t1_id", 0, F_ID, 1);
        expect_v("t1_ex", 0, F_EX, 1);       expect_v("t1_bp", 0, F_BP, 0);
        expect_v("t1_dc0", 0, F_DC, 0);      expect_v("t1_halt0", 0, F_HALT, 0);
        tick(); fence_req = 0;
        expect_v("t1_dc1", 0, F_DC, 3);      expect_v("t1_halt1", 0, F_HALT, 1);
        expect_v("t1_busy1", 0, F_BUSY, 1);  expect_v("t1_wt_dc", 1, F_DC, 0);
        expect_v("t1_wt_halt", 1, F_HALT, 0); expect_v("t1_wt_busy", 1, F_BUSY, 0);
        tick(); ex_valid = 1;
        expect_v("t6_exc_setpc", 0, F_SETPC, 0); expect_v("t6_exc_bp", 0, F_BP, 1);
        expect_v("t6_exc_dc", 0, F_DC, 3);
        tick(); ex_valid = 0; fence_req = 1;
        expect_v("t1_dc3", 0, F_DC, 3);      expect_v("t1_refence", 0, F_SETPC, 1);
        tick(); fence_req = 0; ack = 2'b01;
        expect_v("t1_dc4", 0, F_DC, 3);
        tick(); ack = 2'b00;
        expect_v("t1_dc5", 0, F_DC, 2);
        tick(); ack = 2'b01;
        expect_v("t1_dc6", 0, F_DC, 2);
        tick(); ack = 2'b10;
        expect_v("t1_dc7", 0, F_DC, 2);      expect_v("t1_busy7", 0, F_BUSY, 1);
        tick(); ack = 2'b00;
        expect_v("t1_dc8", 0, F_DC, 0);      expect_v("t1_halt8", 0, F_HALT, 1);
        expect_v("t1_busy8", 0, F_BUSY, 1);  expect_v("t1_ic8", 0, F_IC, 0);
        tick();
        expect_v("t1_busy9", 0, F_BUSY, 0);  expect_v("t1_halt9", 0, F_HALT, 0);
        expect_v("t1_last", 0, F_LAST, 7);

        // T2/T4: FENCE.I, same ack timing
        tick(); fence_i = 1;
        expect_v("t2_ic0", 0, F_IC, 0);      expect_v("t4_ic0", 1, F_IC, 1);
        expect_v("t4_halt", 1, F_HALT, 0);   expect_v("t4_dc", 1, F_DC, 0);
        tick(); fence_i = 0;
        expect_v("t4_ic1", 1, F_IC, 0);      expect_v("t4_busy", 1, F_BUSY, 0);
        expect_v("t2_ic1", 0, F_IC, 0);
        tick(); tick();
        tick(); ack = 2'b01;
        tick(); ack = 2'b00;
        tick();
        tick(); ack = 2'b10;
        expect_v("t2_ic7", 0, F_IC, 0);
        tick(); ack = 2'b00;
        expect_v("t2_ic8", 0, F_IC, 1);      expect_v("t2_ic8_norvh", 2, F_IC, 1);
        tick();
        expect_v("t2_ic9", 0, F_IC, 0);      expect_v("t2_last", 0, F_LAST, 7);

        // T3: FENCE.I with no acks -> abort at c17, deferred I$ flush dropped
        tick(); fence_i = 1;
        tick(); fence_i = 0;
        repeat (14) tick();
        tick();
        expect_v("t3_busy16", 0, F_BUSY, 1); expect_v("t3_dc16", 0, F_DC, 3);
        expect_v("t3_to16", 0, F_TO, 0);
        tick();
        expect_v("t3_to17", 0, F_TO, 1);     expect_v("t3_dc17", 0, F_DC, 0);
        expect_v("t3_busy17", 0, F_BUSY, 0); expect_v("t3_halt17", 0, F_HALT, 0);
        expect_v("t3_last", 0, F_LAST, 16);  expect_v("t3_ic17", 0, F_IC, 0);
        tick();
        expect_v("t3_to18", 0, F_TO, 0);     expect_v("t3_ic18", 0, F_IC, 0);

        // Quick FENCE after abort: no stale I$ flush, one WAIT cycle
        tick(); fence_req = 1;
        tick(); fence_req = 0; ack = 2'b11;
        expect_v("q_dc1", 0, F_DC, 3);
        tick(); ack = 2'b00;
        expect_v("q_busy2", 0, F_BUSY, 1);   expect_v("q_ic2", 0, F_IC, 0);
        expect_v("q_dc2", 0, F_DC, 0);
        tick();
        expect_v("q_last", 0, F_LAST, 1);    expect_v("q_busy3", 0, F_BUSY, 0);

        // Ack arriving on the timeout cycle completes instead of aborting
        tick(); fence_req = 1;
        tick(); fence_req = 0;
        repeat (14) tick();
        tick(); ack = 2'b11;
        expect_v("tb_dc16", 0, F_DC, 3);
        tick(); ack = 2'b00;
        expect_v("tb_to17", 0, F_TO, 0);     expect_v("tb_busy17", 0, F_BUSY, 1);
        expect_v("tb_dc17", 0, F_DC, 0);
        tick();
        expect_v("tb_last", 0, F_LAST, 16);  expect_v("tb_busy18", 0, F_BUSY, 0);
        expect_v("tb_to18", 0, F_TO, 0);

        // T5: TLB strobes
        tick(); v = 1; sfence = 1;
        expect_v("t5_tlb_h", 0, F_TLB, 0);   expect_v("t5_vv_h", 0, F_VV, 1);
        expect_v("t5_tlb_nh", 2, F_TLB, 1);  expect_v("t5_vv_nh", 2, F_VV, 0);
        expect_v("t5_setpc", 0, F_SETPC, 1);
        tick(); v = 0;
        expect_v("t5_tlb_v0", 0, F_TLB, 1);  expect_v("t5_vv_v0", 0, F_VV, 0);
        tick(); sfence = 0; hgvma = 1;
        expect_v("t5_gv_nh", 2, F_GV, 0);    expect_v("t5_setpc_nh", 2, F_SETPC, 0);
        expect_v("t5_if_nh", 2, F_IF, 0);    expect_v("t5_id_nh", 2, F_ID, 0);
        expect_v("t5_gv_h", 0, F_GV, 1);     expect_v("t5_setpc_h", 0, F_SETPC, 1);
        tick(); hgvma = 0; hvvma = 1;
        expect_v("t5_hvv_h", 0, F_VV, 1);    expect_v("t5_hvv_tlb", 0, F_TLB, 0);
        expect_v("t5_hvv_nh", 2, F_VV, 0);

        // T6: exception priority and misc causes
        tick(); clear(); mispredict = 1; ex_valid = 1;
        expect_v("t6_setpc", 0, F_SETPC, 0); expect_v("t6_bp", 0, F_BP, 1);
        expect_v("t6_if", 0, F_IF, 1);
        tick(); ex_valid = 0;
        expect_v("mp_if", 0, F_IF, 1);       expect_v("mp_un", 0, F_UN, 1);
        expect_v("mp_id", 0, F_ID, 0);       expect_v("mp_setpc", 0, F_SETPC, 0);
        expect_v("mp_bp", 0, F_BP, 0);
        tick(); mispredict = 0; eret = 1; flush_csr = 1;
        expect_v("eret_setpc", 0, F_SETPC, 0); expect_v("eret_ex", 0, F_EX, 1);
        tick(); eret = 0;
        expect_v("csr_setpc", 0, F_SETPC, 1); expect_v("csr_bp", 0, F_BP, 0);
        tick(); clear(); halt_csr = 1;
        expect_v("wfi_halt", 0, F_HALT, 1);  expect_v("wfi_halt_wt", 1, F_HALT, 1);
        tick(); halt_csr = 0; flush_commit = 1;
        expect_v("commit_setpc", 0, F_SETPC, 1); expect_v("commit_busy", 0, F_BUSY, 0);
        tick(); clear(); dbg = 1;
        expect_v("dbg_bp", 0, F_BP, 1);      expect_v("dbg_setpc", 0, F_SETPC, 0);

        // Asynchronous reset in the middle of WAIT
        tick(); clear(); fence_req = 1;
        tick(); fence_req = 0;
        tick();
        tick();
        rst = 1;
        #1;
        expect_v("arst_dc", 0, F_DC, 0);     expect_v("arst_busy", 0, F_BUSY, 0);
        expect_v("arst_halt", 0, F_HALT, 0); expect_v("arst_last", 0, F_LAST, 0);
        expect_v("arst_to", 0, F_TO, 0);
        tick(); rst = 0;
        tick();
        expect_v("post_busy", 0, F_BUSY, 0); expect_v("post_dc", 0, F_DC, 0);
        expect_v("post_to", 0, F_TO, 0);

        tick();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
